// File: rtl/trng_conditioner.sv
// rtl/trng_conditioner.sv - ring-oscillator back end: synchroniser, divider, von Neumann corrector,
// word packer with valid/ready output and sticky repetition-count health test
module trng_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DIV  = 4,
  parameter int OUT_WIDTH   = 8,
  parameter int REP_LIMIT   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rnd_in,
  input  logic                 enable,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 health_fail
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam int CNT_W = $clog2(OUT_WIDTH + 1);

  typedef enum logic {EMPTY = 1'b0, HAVE_FIRST = 1'b1} pair_state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DIV_W-1:0]       div_q;
  logic                   prev_q;
  logic [REP_W-1:0]       rep_cnt_q;
  pair_state_t            state_q;
  logic                   first_q;
  logic [OUT_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   data_out_q;
  logic                   data_valid_q;
  logic                   health_fail_q;

  logic s_bit, strobe, emit, full, transfer;

  assign s_bit    = sync_q[SYNC_STAGES-1];
  assign strobe   = enable && (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign emit     = strobe && (state_q == HAVE_FIRST) && (s_bit != first_q);
  assign full     = (cnt_q == CNT_W'(OUT_WIDTH));
  assign transfer = full && !health_fail_q && (!data_valid_q || data_ready);

  // A transfer empties the shifter, so a same-cycle emit starts the next word.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (transfer) cnt_d = '0;
    if (emit && (transfer || !full)) begin
      shreg_d = {shreg_q[OUT_WIDTH-2:0], first_q};
      cnt_d   = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      div_q         <= '0;
      prev_q        <= 1'b0;
      rep_cnt_q     <= '0;
      state_q       <= EMPTY;
      first_q       <= 1'b0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rnd_in};
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;

      if (!enable || strobe) div_q <= '0;
      else                   div_q <= div_q + DIV_W'(1);

      // rep_cnt_q == 0 marks "no previous sample yet" after reset.
      if (strobe) begin
        prev_q <= s_bit;
        if ((rep_cnt_q != '0) && (s_bit == prev_q)) begin
          if (rep_cnt_q != REP_W'(REP_LIMIT)) rep_cnt_q <= rep_cnt_q + REP_W'(1);
        end else begin
          rep_cnt_q <= REP_W'(1);
        end
      end
      if (rep_cnt_q == REP_W'(REP_LIMIT)) health_fail_q <= 1'b1;

      if (!enable) begin
        state_q <= EMPTY;
      end else if (strobe) begin
        case (state_q)
          EMPTY: begin
            first_q <= s_bit;
            state_q <= HAVE_FIRST;
          end
          default: state_q <= EMPTY;
        endcase
      end

      if (transfer) begin
        data_out_q   <= shreg_q;
        data_valid_q <= 1'b1;
      end else if (health_fail_q || data_ready) begin
        data_valid_q <= 1'b0;
      end
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign health_fail = health_fail_q;

endmodule
